sram: RTL and testbench

- Single-clock block RAM used as the data array of the L1 caches.
- Each row is one cache block of 2^LOGWIDTH bits, arranged as WORDSIZE-bit words.
- One read port and one write port operate independently.
- Writes are synchronous, with a per-word write enable. Reads are combinational by default, so the cache controller can use a zero-cycle hit delay.

---
 rtl/sram.sv | 63 ++++++
 tb/tb_sram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram.sv
// Single-clock block RAM holding L1 cache blocks: combinational read, per-word masked write.
// Define SRAM_REGISTERED_READ_EN to register readData (1-cycle read latency).
module sram #(
  parameter int WORDSIZE = 64,
  parameter int LOGWIDTH = 9,
  parameter int LOGDEPTH = 9
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [LOGDEPTH-1:0]                 readAddr,
  output logic [(1<<LOGWIDTH)-1:0]            readData,
  input  logic [LOGDEPTH-1:0]                 writeAddr,
  input  logic [(1<<LOGWIDTH)-1:0]            writeData,
  input  logic [(1<<LOGWIDTH)/WORDSIZE-1:0]   writeEnable
);

  localparam int WIDTH = 1 << LOGWIDTH;
  localparam int WORDS = WIDTH / WORDSIZE;
  localparam int DEPTH = 1 << LOGDEPTH;

  if (WIDTH % WORDSIZE != 0) begin : g_bad_wordsize
    $error("sram: row width %0d is not a multiple of WORDSIZE %0d", WIDTH, WORDSIZE);
  end
  if (WORDS < 1) begin : g_bad_words
    $error("sram: WORDS must be at least 1 (WIDTH %0d, WORDSIZE %0d)", WIDTH, WORDSIZE);
  end

  // Contents are never cleared by reset; a large array cannot be wiped in one cycle.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < WORDS; k++) begin
        if (writeEnable[k])
          mem[writeAddr][k*WORDSIZE +: WORDSIZE] <= writeData[k*WORDSIZE +: WORDSIZE];
        else if (writeEnable[k] !== 1'b0)
          mem[writeAddr][k*WORDSIZE +: WORDSIZE] <= 'x;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && $isunknown(writeEnable))
      $warning("sram: unknown writeEnable %b at row %0d", writeEnable, writeAddr);
  end
`endif

`ifdef SRAM_REGISTERED_READ_EN
  // Loaded before the same edge's write lands, so a same-row collision returns old data.
  logic [WIDTH-1:0] read_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) read_q <= '0;
    else       read_q <= mem[readAddr];
  end

  assign readData = read_q;
`else
  assign readData = mem[readAddr];
`endif

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: vector table plus hand-written sequences, checked
// through a queue of expected read values fed from a behavioural row model.
module tb_sram;
  localparam int DEPTH = 512;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [8:0]   readAddr = '0;
  logic [8:0]   writeAddr = '0;
  logic [511:0] readData;
  logic [511:0] writeData = '0;
  logic [7:0]   writeEnable = '0;

  int total = 0;
  int bad = 0;

  logic [511:0] model [DEPTH];
  logic [511:0] exp_q [$];

  typedef struct {
    logic [8:0]  waddr;
    logic [63:0] base;
    logic [7:0]  we;
    logic [8:0]  raddr;
  } vec_t;
  vec_t vecs [10];

  sram #(.WORDSIZE(64), .LOGWIDTH(9), .LOGDEPTH(9)) dut (
    .clk(clk),
    .reset(reset),
    .readAddr(readAddr),
    .readData(readData),
    .writeAddr(writeAddr),
    .writeData(writeData),
    .writeEnable(writeEnable)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rep(input logic [63:0] w);
    return {8{w}};
  endfunction

  function automatic logic [511:0] lanes(input logic [63:0] b);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = b + 64'(k);
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [8:0] a, input logic [511:0] d, input logic [7:0] we);
    for (int k = 0; k < 8; k++)
      if (we[k]) model[a][k*64 +: 64] = d[k*64 +: 64];
  endtask

  task automatic pop_check(input string name);
    logic [511:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, readData);
    end else begin
      e = exp_q.pop_front();
      check(name, readData, e);
    end
  endtask

  // Plain read; scoreboard expects the modelled row.
  task automatic read_row(input logic [8:0] a, input string name);
    @(negedge clk);
    writeEnable = '0;
    readAddr = a;
    exp_q.push_back(model[a]);
`ifdef SRAM_REGISTERED_READ_EN
    @(posedge clk);
`endif
    #1;
    pop_check(name);
  endtask

  // Write while reading raddr; the read observes the row as it was before the edge.
  task automatic do_write(input logic [8:0] wa, input logic [511:0] d, input logic [7:0] we,
                          input logic [8:0] ra, input string name);
    @(negedge clk);
    writeAddr = wa;
    writeData = d;
    writeEnable = we;
    readAddr = ra;
    exp_q.push_back(model[ra]);
`ifndef SRAM_REGISTERED_READ_EN
    #1;
    pop_check(name);
`endif
    @(posedge clk);
    #1;
`ifdef SRAM_REGISTERED_READ_EN
    pop_check(name);
`endif
    writeEnable = '0;
    model_write(wa, d, we);
  endtask

  logic [511:0] p1, p2, row0_v, row511_v, a5;

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    p1 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666,
          64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    p2 = p1;
    p2[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    row0_v   = rep(64'h0123_4567_89AB_CDEF);
    row511_v = rep(64'hFEDC_BA98_7654_3210);
    a5       = rep(64'hA5A5_A5A5_A5A5_A5A5);

    vecs[0] = '{9'd100, 64'h10, 8'hFF, 9'd100};
    vecs[1] = '{9'd100, 64'h20, 8'h01, 9'd100};
    vecs[2] = '{9'd100, 64'h30, 8'h80, 9'd100};
    vecs[3] = '{9'd100, 64'h40, 8'h00, 9'd100};
    vecs[4] = '{9'd101, 64'h50, 8'h55, 9'd100};
    vecs[5] = '{9'd101, 64'h60, 8'hAA, 9'd101};
    vecs[6] = '{9'd102, 64'h70, 8'h0F, 9'd101};
    vecs[7] = '{9'd511, 64'h80, 8'hF0, 9'd102};
    vecs[8] = '{9'd102, 64'h90, 8'hFF, 9'd511};
    vecs[9] = '{9'd103, 64'hA0, 8'h3C, 9'd102};

    // Reset held with a full-row write pending on row 1: must be dropped.
    writeAddr = 9'd1;
    writeData = rep(64'hBAD0_BAD0_BAD0_BAD0);
    writeEnable = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readData, '0);
    @(negedge clk);
    writeEnable = '0;
    reset = 1'b0;
    read_row(9'd1, "reset_write_dropped");
    check("reset_row1_zero", readData, '0);

    // Full-row write of row 5, visible right after the edge in the combinational build.
    do_write(9'd5, p1, 8'hFF, 9'd5, "s1_pre");
`ifndef SRAM_REGISTERED_READ_EN
    check("s1_same_cycle", readData, p1);
`endif
    read_row(9'd5, "s1_read");
    check("s1_const", readData, p1);

    // Single-lane write.
    do_write(9'd5, {512{1'b1}}, 8'b0000_0100, 9'd5, "s2_pre");
    read_row(9'd5, "s2_read");
    check("s2_const", readData, p2);

    for (int i = 0; i < 10; i++)
      do_write(vecs[i].waddr, lanes(vecs[i].base), vecs[i].we, vecs[i].raddr, $sformatf("vec%0d", i));
    for (int r = 100; r < 104; r++) read_row(9'(r), $sformatf("vec_row%0d", r));
    read_row(9'd511, "vec_row511");

    // Same-row collision on row 7.
    @(negedge clk);
    readAddr = 9'd7;
    writeAddr = 9'd7;
    writeData = a5;
    writeEnable = 8'hFF;
`ifdef SRAM_REGISTERED_READ_EN
    @(posedge clk);
    #1;
    writeEnable = '0;
    check("coll_reg_old", readData, '0);
    @(posedge clk);
    #1;
    check("coll_reg_new", readData, a5);
`else
    #1;
    check("coll_pre", readData, '0);
    @(posedge clk);
    #1;
    writeEnable = '0;
    check("coll_post", readData, a5);
`endif
    model_write(9'd7, a5, 8'hFF);

    // Asynchronous reset mid-cycle with a write pending on row 3.
    @(negedge clk);
    writeAddr = 9'd3;
    writeData = rep(64'hDEAD_BEEF_DEAD_BEEF);
    writeEnable = 8'hFF;
    readAddr = 9'd5;
    #2;
    reset = 1'b1;
    #1;
`ifdef SRAM_REGISTERED_READ_EN
    check("rst_async_clear", readData, '0);
`else
    check("rst_comb_row5", readData, p2);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    writeEnable = '0;
    reset = 1'b0;
`ifdef SRAM_REGISTERED_READ_EN
    #1;
    check("rst_hold_zero", readData, '0);
`endif
    read_row(9'd3, "rst_row3");
    check("rst_row3_zero", readData, '0);
    read_row(9'd5, "rst_row5");
    check("rst_row5_const", readData, p2);

    // Boundary rows.
    do_write(9'd0, row0_v, 8'hFF, 9'd511, "bnd_w0");
    do_write(9'd511, row511_v, 8'hFF, 9'd0, "bnd_w511");
    read_row(9'd0, "bnd_r0");
    check("bnd_row0_const", readData, row0_v);
    read_row(9'd511, "bnd_r511");
    check("bnd_row511_const", readData, row511_v);

    // Independent ports: hammer row 10 while row 20 is read.
    do_write(9'd20, rep(64'h2020_2020_2020_2020), 8'hFF, 9'd20, "ind_fill");
    for (int i = 1; i <= 16; i++) begin
      do_write(9'd10, rep(64'(i)), 8'hFF, 9'd20, $sformatf("ind_cyc%0d", i));
      check($sformatf("ind_row20_%0d", i), readData, rep(64'h2020_2020_2020_2020));
    end
    read_row(9'd10, "ind_row10");
    check("ind_row10_const", readData, rep(64'd16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
